// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int WORD_WIDTH     = 8 * BYTES_PER_WORD;
  localparam int CHECKSUM_WIDTH = 32;
  localparam int LEN_WIDTH      = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic is_busy_state(input state_e s);
    return (s == ST_LOAD) || (s == ST_CHECK);
  endfunction

  function automatic logic accepts_start(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Big-endian byte-to-word assembler: the first byte of a word lands in bits 31:24.
// word_o/word_ready_o describe the word completed by the byte accepted this cycle.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  word_ready_o
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [WORD_WIDTH-9:0]  shift_q, shift_d;
  logic [BYTE_IDX_W-1:0]  idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[WORD_WIDTH-17:0], byte_i};
      idx_d   = idx_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign word_o       = {shift_q, byte_i};
  assign word_ready_o = byte_valid_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Program loader: streams bytes into 32-bit instruction-memory writes and holds
// the CPU until a load completes. Define IMEM_LOADER_CHECKSUM_EN to require a
// trailing 32-bit checksum word before a load is accepted.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len_words,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // Wide enough that base + 4*len can never wrap during the range check.
  localparam int EW = ADDR_WIDTH + LEN_WIDTH + 3;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  word_idx_q;

  logic                  s_ready_q, s_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic                  start_ok;
  logic                  req_ok;
  logic [EW-1:0]         end_addr;
  logic                  pk_ready;
  logic [WORD_WIDTH-1:0] pk_word;
  logic                  load_word;
  logic                  last_word;
  logic                  all_written;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] sum_q;
`endif

  assign accept   = s_ready_q && s_valid;
  assign start_ok = start && accepts_start(state_q);

  assign end_addr = EW'(base_addr) + EW'({len_words, 2'b00});
  assign req_ok   = (base_addr[1:0] == 2'b00)
                 && (len_words != '0)
                 && (len_words <= LEN_WIDTH'(MAX_WORDS))
                 && (end_addr <= (EW'(1) << ADDR_WIDTH));

  imem_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_ok),
    .byte_valid_i (accept),
    .byte_i       (s_data),
    .word_o       (pk_word),
    .word_ready_o (pk_ready)
  );

  assign load_word   = (state_q == ST_LOAD) && pk_ready;
  assign last_word   = load_word && (word_idx_q == len_q - 1'b1);
  assign all_written = mem_we_q && (word_idx_q == len_q);

  // State register plus every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) state_d = req_ok ? ST_LOAD : ST_ERR;
      end
      ST_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (all_written) state_d = ST_CHECK;
`else
        if (all_written) state_d = ST_DONE;
`endif
      end
      ST_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (pk_ready) state_d = (pk_word == sum_q) ? ST_DONE : ST_ERR;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic, computed from the next state so the flops carry it.
  always_comb begin
    s_ready_d   = ((state_d == ST_LOAD) && !last_word) || (state_d == ST_CHECK);
    mem_we_d    = load_word;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (load_word) begin
      mem_addr_d  = base_q + ADDR_WIDTH'({word_idx_q, 2'b00});
      mem_wdata_d = pk_word;
    end
    busy_d     = is_busy_state(state_d);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
    cpu_hold_d = (state_d != ST_DONE);
  end

  // Load parameters and word counter; the stored base/len are only used in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
    end else if (start_ok) begin
      base_q     <= base_addr;
      len_q      <= len_words;
      word_idx_q <= '0;
    end else if (load_word) begin
      word_idx_q <= word_idx_q + 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (load_word) begin
      sum_q <= sum_q + CHECKSUM_WIDTH'(pk_word);
    end
  end
`endif

  assign s_ready   = s_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the pipeline's byte-addressed instruction memory before execution. Accepts a byte stream with valid/ready, packs four bytes per instruction word in big-endian order (first byte to the lowest address, bits 31:24), and issues one word write per instruction into the memory's write port. Holds the CPU in stall from reset until a load completes successfully.

## Interface
- ADDR_WIDTH, 12, byte-address width of instruction memory (4096 bytes)
- MAX_WORDS, 1024, largest accepted len_words
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE, DONE or ERR
- base_addr  in  ADDR_WIDTH  byte address of first word; must be word aligned
- len_words  in  11  number of 32-bit words to load
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  one-cycle word write strobe
- mem_addr  out  ADDR_WIDTH  byte address of the word written (multiple of 4)
- mem_wdata  out  32  word; bits 31:24 go to mem_addr, bits 7:0 to mem_addr+3
- cpu_hold  out  1  stall/reset request to pipeline
- busy  out  1  load in progress
- done  out  1  last load completed without error (level)
- error  out  1  last load rejected or failed (level)

## Operation
- States: IDLE, LOAD, CHECK (macro only), DONE, ERR.
- IDLE/DONE/ERR + start: validate; misaligned base_addr, len_words==0, len_words>MAX_WORDS, or base_addr+4*len_words > 2^ADDR_WIDTH -> ERR, no writes; else -> LOAD, word counter 0, done/error cleared.
- LOAD: s_ready=1; byte accepted on s_valid&&s_ready; byte index 0..3 shifts into word MSB-first. On 4th byte: next cycle mem_we=1, mem_addr=base_addr+4*word_idx, mem_wdata=packed word; word_idx increments.
- After write of word len_words-1: -> DONE (or CHECK with macro). No bytes accepted after the last word in LOAD.
- start while busy: ignored. s_valid while not LOAD: ignored, s_ready=0.
- cpu_hold: 1 from reset, 1 in IDLE, LOAD, CHECK, ERR; 0 only in DONE.
- busy=1 in LOAD and CHECK. done=1 only in DONE; error=1 only in ERR.
- Reset mid-load: immediately returns to IDLE; partial words discarded; already written words remain in memory.

## Timing
- Reset values: s_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, busy 0, done 0, error 0.
- start to s_ready high: 1 cycle. start to error (rejected): 1 cycle.
- 4th byte accept edge -> mem_we high for exactly the following cycle; s_ready stays high then, so back-to-back streaming sustains 1 byte/cycle, 1 word write per 4 cycles.
- Final mem_we cycle -> DONE (done=1, cpu_hold=0) on the next edge.
- All outputs registered; mem_addr/mem_wdata hold last values when mem_we=0.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the last word, CHECK accepts 4 more bytes (big-endian) as the expected 32-bit sum modulo 2^32 of all loaded words; match -> DONE, mismatch -> ERR (cpu_hold stays 1). No write issued for checksum bytes.
- Undefined: no CHECK state; LOAD goes directly to DONE; stream length is exactly 4*len_words bytes.

## Structure
- Package imem_loader_pkg: state enum, BYTES_PER_WORD=4 constant, checksum width constant.
- Sub-module imem_byte_packer: byte shift register, 2-bit byte index, word_ready pulse; reused for checksum byte assembly.

## Test plan
- Reset, base 0, len 3, stream 00 22 18 21 / 00 01 28 21 / 00 23 20 21 back-to-back -> writes 0x00221821@0, 0x00012821@4, 0x00232021@8; done=1, cpu_hold=0 one cycle after last write.
- Same stream with s_valid toggling every other cycle -> identical writes, no duplicates/drops.
- base_addr 2 or len_words 0 or base 4092 len 2 -> error=1 next cycle, mem_we never asserted, cpu_hold=1.
- rst_n low after 6 bytes of a 3-word load -> all outputs at reset values asynchronously; new load from start writes correctly.
- start pulsed during LOAD -> ignored; word counter and addresses unaffected.
- Macro on: 2 words 0x00000001, 0x00000002 then checksum 00 00 00 03 -> DONE; checksum 00 00 00 04 -> ERR, cpu_hold=1.
